// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the ALU scheduler.
//   - state_t       : scheduler FSM states (IDLE, EXEC, DONE)
//   - OPW           : ALU opcode width
//   - OP_* / *TYPE  : ALU opcode and instruction-type encodings
//   - is_multicycle : true for mul/div/rem ops that need a held multicycle path
package alu_sched_pkg;

  localparam int OPW = 11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [OPW-1:0] OP_NOTHING = 11'd0;
  localparam logic [OPW-1:0] OP_ADD     = 11'd1;
  localparam logic [OPW-1:0] OP_SUB     = 11'd2;
  localparam logic [OPW-1:0] OP_AND     = 11'd3;
  localparam logic [OPW-1:0] OP_OR      = 11'd4;
  localparam logic [OPW-1:0] OP_XOR     = 11'd5;
  localparam logic [OPW-1:0] OP_SLL     = 11'd6;
  localparam logic [OPW-1:0] OP_SRL     = 11'd7;
  localparam logic [OPW-1:0] OP_SRA     = 11'd8;
  localparam logic [OPW-1:0] OP_SLT     = 11'd9;
  localparam logic [OPW-1:0] OP_SLTU    = 11'd10;
  localparam logic [OPW-1:0] OP_MUL     = 11'd11;
  localparam logic [OPW-1:0] OP_MULH    = 11'd12;
  localparam logic [OPW-1:0] OP_MULHU   = 11'd13;
  localparam logic [OPW-1:0] OP_MULHSU  = 11'd14;
  localparam logic [OPW-1:0] OP_DIV     = 11'd15;
  localparam logic [OPW-1:0] OP_DIVU    = 11'd16;
  localparam logic [OPW-1:0] OP_REM     = 11'd17;
  localparam logic [OPW-1:0] OP_REMU    = 11'd18;

  localparam logic [3:0] RTYPE = 4'd0;
  localparam logic [3:0] ITYPE = 4'd1;
  localparam logic [3:0] STYPE = 4'd2;
  localparam logic [3:0] BTYPE = 4'd3;
  localparam logic [3:0] UTYPE = 4'd4;
  localparam logic [3:0] JTYPE = 4'd5;

  function automatic logic is_multicycle(input logic [OPW-1:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: request, ALU and response buses of the ALU scheduler.
//   req_*  : per-requester valid/ready + packed payload (slot i = index i)
//   alu_*  : registered operands towards the shared ALU, alu_result back
//   resp_* : valid/ready result channel tagged with requester index
// Modports: slave = scheduler, master = requesters/ALU/consumer side.
interface alu_sched_if import alu_sched_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) ();

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][OPW-1:0]  req_opcode;
  logic [NREQ-1:0][63:0]     req_value1;
  logic [NREQ-1:0][63:0]     req_value2;
  logic [NREQ-1:0][31:0]     req_immediate;
  logic [NREQ-1:0][5:0]      req_shamt;
  logic [NREQ-1:0][3:0]      req_instr_type;

  logic [OPW-1:0]            alu_opcode;
  logic [63:0]               alu_value1;
  logic [63:0]               alu_value2;
  logic [31:0]               alu_immediate;
  logic [5:0]                alu_shamt;
  logic [3:0]                alu_instr_type;
  logic [63:0]               alu_result;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [IDW-1:0]            resp_id;
  logic [63:0]               resp_result;

  modport slave (
    input  req_valid, req_opcode, req_value1, req_value2,
           req_immediate, req_shamt, req_instr_type,
    output req_ready,
    output alu_opcode, alu_value1, alu_value2, alu_immediate,
           alu_shamt, alu_instr_type,
    input  alu_result,
    output resp_valid, resp_id, resp_result,
    input  resp_ready
  );

  modport master (
    output req_valid, req_opcode, req_value1, req_value2,
           req_immediate, req_shamt, req_instr_type,
    input  req_ready,
    input  alu_opcode, alu_value1, alu_value2, alu_immediate,
           alu_shamt, alu_instr_type,
    output alu_result,
    input  resp_valid, resp_id, resp_result,
    output resp_ready
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter with a registered pointer.
//   clk, rst_n : clock, async active-low reset (pointer -> 0)
//   req        : request vector
//   en         : grant may be consumed this cycle (pointer advances if any req)
//   grant      : one-hot grant (unmasked by en)
//   grant_idx  : index of the granted requester
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW:0]   cand;
  logic          found;

  // Scan N slots starting at ptr; first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!found && req[cand[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = grant_idx + 1'b1;
    if (grant_idx == PW'(N-1)) ptr_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ptr <= '0;
    else if (en && found) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational 64-bit ALU among NREQ requesters.
//   clk, reset_n : clock, async active-low reset
//   bus          : alu_sched_if.slave (requests, ALU operands/result, response)
//   perf_busy    : (ALU_SCHED_PERF_EN) cycles spent outside IDLE
//   perf_grants  : (ALU_SCHED_PERF_EN) per-requester handshake counts
// Round-robin grant; operands are registered and held for 1 cycle (single
// cycle ops) or MC_CYCLES cycles (mul/div/rem) before the result is captured
// and offered on the response channel. Optional counters are enabled by
// defining ALU_SCHED_PERF_EN.
module alu_sched import alu_sched_pkg::*; #(
  parameter int NREQ      = 2,
  parameter int MC_CYCLES = 4,
  parameter int IDW       = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_sched_if.slave bus
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_busy,
  output logic [NREQ-1:0][31:0] perf_grants
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MC_CYCLES);
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES-1);

  state_t          state, state_nxt;
  logic            can_accept, hs;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   cnt;

  logic [OPW-1:0]  op_q;
  logic [63:0]     v1_q, v2_q;
  logic [31:0]     imm_q;
  logic [5:0]      shamt_q;
  logic [3:0]      itype_q;
  logic [IDW-1:0]  id_q;
  logic [63:0]     res_q;

  // DONE can hand off to a new request in the same cycle its result drains.
  assign can_accept    = (state == IDLE) | ((state == DONE) & bus.resp_ready);
  assign bus.req_ready = grant & {NREQ{can_accept}};
  assign hs            = |bus.req_ready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       (bus.req_valid),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = hs ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result datapath. op_q is forced back to NOTHING as EXEC ends so
  // the ALU only ever sees a live opcode while an op is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_NOTHING;
      v1_q    <= '0;
      v2_q    <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
      itype_q <= '0;
      id_q    <= '0;
      res_q   <= '0;
      cnt     <= '0;
    end else if (hs) begin
      op_q    <= bus.req_opcode[gidx];
      v1_q    <= bus.req_value1[gidx];
      v2_q    <= bus.req_value2[gidx];
      imm_q   <= bus.req_immediate[gidx];
      shamt_q <= bus.req_shamt[gidx];
      itype_q <= bus.req_instr_type[gidx];
      id_q    <= IDW'(gidx);
      cnt     <= is_multicycle(bus.req_opcode[gidx]) ? MC_LOAD : '0;
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        // NOTHING returns zero regardless of what the ALU drives.
        res_q <= (op_q == OP_NOTHING) ? 64'd0 : bus.alu_result;
        op_q  <= OP_NOTHING;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.alu_opcode     = op_q;
  assign bus.alu_value1     = v1_q;
  assign bus.alu_value2     = v2_q;
  assign bus.alu_immediate  = imm_q;
  assign bus.alu_shamt      = shamt_q;
  assign bus.alu_instr_type = itype_q;
  assign bus.resp_valid     = (state == DONE);
  assign bus.resp_id        = id_q;
  assign bus.resp_result    = res_q;

`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy   <= '0;
      perf_grants <= '0;
    end else begin
      if (state != IDLE) perf_busy <= perf_busy + 32'd1;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[i]) perf_grants[i] <= perf_grants[i] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched (NREQ=2, MC=4).
// A small behavioural ALU drives alu_result; expected values are constants.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int MC   = 4;
  localparam int IDW  = 2;
  localparam int PW   = $clog2(NREQ);

  typedef logic [PW-1:0] rid_t;

  typedef struct {
    rid_t         id;
    logic [10:0]  op;
    logic [63:0]  v1;
    logic [63:0]  v2;
    logic [63:0]  exp;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef ALU_SCHED_PERF_EN
  logic [31:0]           perf_busy;
  logic [NREQ-1:0][31:0] perf_grants;
`endif

  alu_sched #(.NREQ(NREQ), .MC_CYCLES(MC), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_SCHED_PERF_EN
    ,
    .perf_busy   (perf_busy),
    .perf_grants (perf_grants)
`endif
  );

  // Behavioural ALU. NOTHING drives garbage so the zero-result rule is exercised.
  logic [63:0] alu_r;
  logic signed [63:0] sa, sb;
  assign sa = bus.alu_value1;
  assign sb = bus.alu_value2;
  always_comb begin
    alu_r = 64'hDEAD_BEEF_0BAD_F00D;
    case (bus.alu_opcode)
      OP_ADD:  alu_r = bus.alu_value1 + bus.alu_value2;
      OP_SUB:  alu_r = bus.alu_value1 - bus.alu_value2;
      OP_XOR:  alu_r = bus.alu_value1 ^ bus.alu_value2;
      OP_MUL:  alu_r = bus.alu_value1 * bus.alu_value2;
      OP_DIV:  alu_r = (sb == 0) ? '1 : 64'(sa / sb);
      OP_DIVU: alu_r = (bus.alu_value2 == 0) ? '1 : bus.alu_value1 / bus.alu_value2;
      OP_REM:  alu_r = (sb == 0) ? bus.alu_value1 : 64'(sa % sb);
      OP_REMU: alu_r = (bus.alu_value2 == 0) ? bus.alu_value1 : bus.alu_value1 % bus.alu_value2;
      default: ;
    endcase
  end
  assign bus.alu_result = alu_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid      = '0;
    bus.req_opcode     = '0;
    bus.req_value1     = '0;
    bus.req_value2     = '0;
    bus.req_immediate  = '0;
    bus.req_shamt      = '0;
    bus.req_instr_type = '0;
  endtask

  task automatic load_slot(input rid_t id, input logic [10:0] op,
                           input logic [63:0] v1, input logic [63:0] v2);
    bus.req_opcode[id]     = op;
    bus.req_value1[id]     = v1;
    bus.req_value2[id]     = v2;
    bus.req_immediate[id]  = 32'h0;
    bus.req_shamt[id]      = 6'h0;
    bus.req_instr_type[id] = RTYPE;
  endtask

  // Present a request and return #1 after its handshake edge.
  task automatic issue(input rid_t id, input logic [10:0] op,
                       input logic [63:0] v1, input logic [63:0] v2);
    bit done;
    done = 1'b0;
    load_slot(id, op, v1, v2);
    bus.req_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no req_ready required req_ready on slot %0d", id);
      bus.req_valid[id] = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int  lat;
    bit  held;
    lat  = 0;
    held = 1'b1;
    issue(v.id, v.op, v.v1, v.v2);
    while (lat < 20) begin
      if (bus.alu_opcode !== v.op || bus.alu_value1 !== v.v1 || bus.alu_value2 !== v.v2)
        held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (bus.resp_valid) break;
    end
    chk($sformatf("vec%0d_latency", n), 64'(lat), 64'(v.lat));
    chk($sformatf("vec%0d_result", n), bus.resp_result, v.exp);
    chk($sformatf("vec%0d_id", n), 64'(bus.resp_id), 64'(v.id));
    chk($sformatf("vec%0d_inputs_held", n), 64'(held), 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{id: 1'b0, op: OP_ADD,     v1: 64'd5,   v2: 64'd7,   exp: 64'd12, lat: 1};
    vecs[1] = '{id: 1'b1, op: OP_SUB,     v1: 64'd9,   v2: 64'd4,   exp: 64'd5,  lat: 1};
    vecs[2] = '{id: 1'b1, op: OP_DIV,     v1: 64'd100, v2: 64'd7,   exp: 64'd14, lat: MC};
    vecs[3] = '{id: 1'b1, op: OP_REM,     v1: 64'd100, v2: 64'd7,   exp: 64'd2,  lat: MC};
    vecs[4] = '{id: 1'b0, op: OP_MUL,     v1: 64'd3,   v2: -64'sd4, exp: 64'hFFFF_FFFF_FFFF_FFF4, lat: MC};
    vecs[5] = '{id: 1'b0, op: OP_NOTHING, v1: 64'd5,   v2: 64'd7,   exp: 64'd0,  lat: 1};
    vecs[6] = '{id: 1'b1, op: OP_DIVU,    v1: 64'd100, v2: 64'd0,   exp: 64'hFFFF_FFFF_FFFF_FFFF, lat: MC};
    vecs[7] = '{id: 1'b0, op: OP_XOR,     v1: 64'hF0,  v2: 64'hFF,  exp: 64'h0F, lat: 1};

    idle_inputs();
    bus.resp_ready = 1'b1;
    reset_n        = 1'b0;

    // Reset state
    #12;
    chk("rst_alu_opcode",  64'(bus.alu_opcode), 64'(OP_NOTHING));
    chk("rst_resp_valid",  64'(bus.resp_valid), 64'd0);
    chk("rst_req_ready",   64'(bus.req_ready),  64'd0);
    chk("rst_resp_result", bus.resp_result,     64'd0);
    chk("rst_resp_id",     64'(bus.resp_id),    64'd0);
    chk("rst_alu_value1",  bus.alu_value1,      64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table of single requests
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    repeat (3) @(posedge clk);
    #1;

    // Fairness: both requesters valid continuously, pointer starts at 0
    begin
      int   ng, nr;
      rid_t g_seen [4];
      logic [63:0] r_seen [4];
      logic [IDW-1:0] i_seen [4];
      ng = 0; nr = 0;
      do_reset();
      load_slot(1'b0, OP_ADD, 64'd1, 64'd1);
      load_slot(1'b1, OP_SUB, 64'd9, 64'd4);
      bus.req_valid = 2'b11;
      for (int c = 0; c < 40 && (ng < 4 || nr < 4); c++) begin
        @(negedge clk);
        if (bus.resp_valid && nr < 4) begin
          r_seen[nr] = bus.resp_result;
          i_seen[nr] = bus.resp_id;
          nr++;
        end
        if (bus.req_ready != '0 && ng < 4) begin
          g_seen[ng] = bus.req_ready[1] ? 1'b1 : 1'b0;
          ng++;
        end
      end
      bus.req_valid = '0;
      chk("fair_grant_count", 64'(ng), 64'd4);
      chk("fair_resp_count",  64'(nr), 64'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < ng) chk($sformatf("fair_grant%0d", k), 64'(g_seen[k]), 64'(k % 2));
        if (k < nr) begin
          chk($sformatf("fair_result%0d", k), r_seen[k], (k % 2 == 0) ? 64'd2 : 64'd5);
          chk($sformatf("fair_id%0d", k), 64'(i_seen[k]), 64'(k % 2));
        end
      end
      repeat (8) @(posedge clk);
      #1;
    end

    // Backpressure on a MUL result, then same-cycle release + new handshake
    begin
      int w;
      bus.resp_ready = 1'b0;
      issue(1'b0, OP_MUL, 64'd3, -64'sd4);
      w = 0;
      while (!bus.resp_valid && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      chk("bp_mul_latency", 64'(w), 64'(MC));
      load_slot(1'b0, OP_ADD, 64'd5, 64'd7);
      bus.req_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("bp_hold_valid_ready%0d", c), 64'({bus.resp_valid, bus.req_ready}), 64'b100);
        chk($sformatf("bp_hold_result%0d", c), bus.resp_result, 64'hFFFF_FFFF_FFFF_FFF4);
      end
      bus.resp_ready = 1'b1;
      #1;
      chk("bp_release_req_ready", 64'(bus.req_ready), 64'b01);
      @(posedge clk); #1;
      bus.req_valid = '0;
      chk("bp_direct_exec_valid", 64'(bus.resp_valid), 64'd0);
      chk("bp_direct_exec_op",    64'(bus.alu_opcode), 64'(OP_ADD));
      @(posedge clk); #1;
      chk("bp_add_valid",  64'(bus.resp_valid), 64'd1);
      chk("bp_add_result", bus.resp_result, 64'd12);
      @(posedge clk); #1;
    end

    // Reset in the 2nd EXEC cycle of a DIVU discards it
    begin
      bit stale;
      vec_t vn;
      stale = 1'b0;
      issue(1'b0, OP_DIVU, 64'd100, 64'd7);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("midrst_alu_opcode", 64'(bus.alu_opcode), 64'(OP_NOTHING));
      chk("midrst_alu_value1", bus.alu_value1, 64'd0);
      chk("midrst_req_ready",  64'(bus.req_ready), 64'd0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.resp_valid) stale = 1'b1;
      end
      chk("midrst_no_stale_resp", 64'(stale), 64'd0);
      @(posedge clk); #1;
      vn = '{id: 1'b0, op: OP_NOTHING, v1: 64'd55, v2: 64'd1, exp: 64'd0, lat: 1};
      run_vec(vn, 8);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
